// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises configuration words onto one CCFF chain.
//
// Words arrive on a valid/ready stream and are shifted out LSB first on
// ccff_head, with config_enable high for exactly CHAIN_LEN shift edges per
// load. Bits leaving the chain on ccff_tail are counted during the same
// shifts.
//
// Ports:
//   prog_clock     programming clock shared with the chain
//   prog_reset     asynchronous active-low reset
//   start          one-cycle load request, honoured only in idle
//   word_valid     word_data is valid
//   word_data      configuration word, bit 0 shifted first
//   word_ready     loader accepts word_data this cycle
//   config_enable  registered chain shift enable
//   ccff_head      registered serial bit into the chain
//   ccff_tail      serial bit leaving the chain
//   busy           load in progress
//   done           one-cycle pulse after the final shift
//   bit_count      shifts completed in the current/last load
//   readback_ones  ones sampled on ccff_tail during the load
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 66,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clock,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              config_enable,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [CNT_W-1:0]  readback_ones
);

  localparam int unsigned      WbW      = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WbW-1:0]   WordBits = WbW'(WORD_W);

  typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WbW-1:0]    word_bits_q, word_bits_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic              cfg_en_q, cfg_en_d;
  logic              head_q, head_d;
  logic              last_bit;

  assign last_bit = (word_bits_q == WbW'(1));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    word_bits_d = word_bits_q;
    bit_count_d = bit_count_q;
    ones_d      = ones_q;
    word_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFetch;
          bit_count_d = '0;
          ones_d      = '0;
        end
      end
      StFetch: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) begin
          shift_d     = word_data;
          word_bits_d = WordBits;
          state_d     = StShift;
        end
      end
      StShift: begin
        busy        = 1'b1;
        // Accept the next word on the last bit so the stream stays gapless,
        // but never fetch a word the chain does not need.
        word_ready  = last_bit && (bit_count_q < LastIdx);
        shift_d     = shift_q >> 1;
        word_bits_d = word_bits_q - 1'b1;
        bit_count_d = bit_count_q + 1'b1;
        ones_d      = ones_q + CNT_W'(ccff_tail);
        if (bit_count_q == LastIdx) begin
          state_d = StDone;
        end else if (last_bit) begin
          if (word_valid) begin
            shift_d     = word_data;
            word_bits_d = WordBits;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Enable and head are registered from next state so the chain sees them
    // aligned with the shift register contents.
    cfg_en_d = (state_d == StShift);
    head_d   = (state_d == StShift) ? shift_d[0] : 1'b0;
  end

  always_ff @(posedge prog_clock or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      word_bits_q <= '0;
      bit_count_q <= '0;
      ones_q      <= '0;
      cfg_en_q    <= 1'b0;
      head_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      word_bits_q <= word_bits_d;
      bit_count_q <= bit_count_d;
      ones_q      <= ones_d;
      cfg_en_q    <= cfg_en_d;
      head_q      <= head_d;
    end
  end

  assign config_enable = cfg_en_q;
  assign ccff_head     = head_q;
  assign bit_count     = bit_count_q;
  assign readback_ones = ones_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: a 66-bit chain instance with a behavioural
// chain attached, plus a 1-bit chain instance for the minimum length case.
module tb_ccff_chain_loader;

  localparam int unsigned Len       = 66;
  localparam int unsigned Ww        = 8;
  localparam int unsigned Cw        = $clog2(Len + 1);
  localparam int          NeedWords = (Len + Ww - 1) / Ww;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start0 = 1'b0, valid0 = 1'b0;
  logic [Ww-1:0] data0 = '0;
  logic          ready0, en0, head0, tail0, busy0, done0;
  logic [Cw-1:0] bc0, ro0;

  logic          start1 = 1'b0, valid1 = 1'b0;
  logic [Ww-1:0] data1 = '0;
  logic          ready1, en1, head1, tail1, busy1, done1;
  logic [0:0]    bc1, ro1;

  ccff_chain_loader #(.CHAIN_LEN(Len), .WORD_W(Ww)) dut0 (
    .prog_clock(clk), .prog_reset(rst_n), .start(start0), .word_valid(valid0),
    .word_data(data0), .word_ready(ready0), .config_enable(en0), .ccff_head(head0),
    .ccff_tail(tail0), .busy(busy0), .done(done0), .bit_count(bc0), .readback_ones(ro0)
  );

  ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(Ww)) dut1 (
    .prog_clock(clk), .prog_reset(rst_n), .start(start1), .word_valid(valid1),
    .word_data(data1), .word_ready(ready1), .config_enable(en1), .ccff_head(head1),
    .ccff_tail(tail1), .busy(busy1), .done(done1), .bit_count(bc1), .readback_ones(ro1)
  );

  // Chain: head enters at the top, tail leaves from bit 0, so after a full
  // load chain0[i] holds the i-th bit of the stream.
  logic [Len-1:0] chain0;
  logic           pre_en  = 1'b0;
  logic [Len-1:0] pre_val = '0;
  always @(posedge clk) begin
    if (pre_en) chain0 <= pre_val;
    else if (en0) chain0 <= {head0, chain0[Len-1:1]};
  end
  assign tail0 = chain0[0];

  logic chain1 = 1'b0;
  always @(posedge clk) if (en1) chain1 <= head1;
  assign tail1 = chain1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [Ww-1:0]  words[$];
  logic [Len-1:0] basic_chain;

  int r_en_cycles, r_first_en, r_last_en, r_done_cnt, r_xfers, r_ready_late;
  int r_bc_bad, r_stall_cnt, r_stall_bad, r_idle_bad, r_ro_at_done, r_bc_final;
  bit r_timeout, r_done_en, r_busy_start;

  // Expected chain content: first Len bits of the word stream, LSB first.
  function automatic logic [Len-1:0] stream_of();
    logic [Len-1:0] s;
    logic [Ww-1:0]  w;
    s = '0;
    for (int i = 0; i < Len; i++) begin
      w    = words[i / Ww];
      s[i] = w[i % Ww];
    end
    return s;
  endfunction

  function automatic int popcount(input logic [Len-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < Len; i++) n += int'(v[i]);
    return n;
  endfunction

  // kind 0: 1,2,3..; kind 1: random; kind 2: all ones. One spare word is
  // always offered so over-fetching shows up.
  task automatic fill_words(input int kind);
    words.delete();
    for (int i = 0; i < NeedWords + 1; i++) begin
      if (kind == 0) words.push_back(Ww'(i + 1));
      else if (kind == 1) words.push_back(Ww'($urandom));
      else words.push_back('1);
    end
  endtask

  task automatic preload(input logic [Len-1:0] v);
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk); #1;
    pre_en  = 1'b0;
  endtask

  // Runs one load from idle; entered and left at 1 time unit after an edge.
  task automatic run_load(input int stall_idx, input int stall_len, input bit spam);
    int cyc, idx, shifts;
    bit done_prev;
    logic [Len-1:0] snap;
    cyc = 0; idx = 0; shifts = 0; done_prev = 1'b0; snap = '0;
    r_en_cycles = 0; r_first_en = -1; r_last_en = -1; r_done_cnt = 0; r_xfers = 0;
    r_ready_late = 0; r_bc_bad = 0; r_stall_cnt = 0; r_stall_bad = 0; r_idle_bad = 0;
    r_ro_at_done = 0; r_bc_final = 0; r_timeout = 1'b0; r_done_en = 1'b0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    r_busy_start = busy0;
    forever begin
      if (bc0 !== Cw'(shifts)) r_bc_bad++;
      if (done_prev) begin
        r_bc_final = int'(bc0);
        if (busy0 || ready0 || done0 || en0) r_idle_bad++;
        break;
      end
      if (cyc > 600) begin
        r_timeout = 1'b1;
        break;
      end
      done_prev = done0;
      if (done0) begin
        r_done_cnt++;
        r_ro_at_done = int'(ro0);
        r_done_en    = en0;
        start0       = spam;
      end
      if (en0) begin
        if (r_first_en < 0) r_first_en = cyc;
        r_last_en = cyc;
        r_en_cycles++;
        shifts++;
      end
      if (ready0 && idx >= NeedWords) r_ready_late++;
      valid0 = 1'b0;
      data0  = '0;
      if (idx < words.size()) begin
        valid0 = 1'b1;
        data0  = words[idx];
      end
      if (idx == stall_idx && r_stall_cnt < stall_len) begin
        valid0 = 1'b0;
        if (!en0) begin
          if (r_stall_cnt == 0) snap = chain0;
          else if (chain0 !== snap) r_stall_bad++;
          r_stall_cnt++;
        end
      end
      if (valid0 && ready0) begin
        idx++;
        r_xfers++;
      end
      if (spam && en0 && shifts == 10) start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      cyc++;
    end
    valid0 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({en0, head0, ready0, busy0, done0} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {en0, head0, ready0, busy0, done0});
    end
    n_cmp++;
    if (bc0 !== '0 || ro0 !== '0) begin
      n_bad++;
      $display("FAIL reset_counts: got bc=%0d ro=%0d want 0 0", bc0, ro0);
    end
    n_cmp++;
    if ({en1, ready1, busy1, done1, bc1} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_len1: got %b want 00000", {en1, ready1, busy1, done1, bc1});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    preload('0);
  endtask

  task automatic test_basic;
    logic [Len-1:0] exp, old;
    fill_words(0);
    exp = stream_of();
    old = chain0;
    run_load(-1, 0, 1'b0);
    basic_chain = chain0;
    n_cmp++;
    if (r_timeout || r_busy_start !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_start: timeout=%0d busy=%0d want 0 1", r_timeout, r_busy_start);
    end
    n_cmp++;
    if (r_en_cycles != Len || r_last_en - r_first_en + 1 != Len) begin
      n_bad++;
      $display("FAIL basic_en_run: got %0d cycles span %0d want %0d", r_en_cycles,
               r_last_en - r_first_en + 1, Len);
    end
    n_cmp++;
    if (chain0 !== exp) begin
      n_bad++;
      $display("FAIL basic_chain: got %h want %h", chain0, exp);
    end
    n_cmp++;
    if (r_done_cnt != 1 || r_done_en !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done: got %0d pulses en=%0d want 1 0", r_done_cnt, r_done_en);
    end
    n_cmp++;
    if (r_xfers != NeedWords || r_ready_late != 0) begin
      n_bad++;
      $display("FAIL basic_xfers: got %0d late_ready=%0d want %0d 0", r_xfers, r_ready_late,
               NeedWords);
    end
    n_cmp++;
    if (r_bc_bad != 0 || r_bc_final != Len || r_idle_bad != 0) begin
      n_bad++;
      $display("FAIL basic_bit_count: bad=%0d final=%0d idle_bad=%0d want 0 %0d 0", r_bc_bad,
               r_bc_final, r_idle_bad, Len);
    end
    n_cmp++;
    if (r_ro_at_done != popcount(old)) begin
      n_bad++;
      $display("FAIL basic_readback: got %0d want %0d", r_ro_at_done, popcount(old));
    end
  endtask

  task automatic test_stall;
    preload(Len'({$urandom, $urandom, $urandom}));
    fill_words(0);
    run_load(3, 5, 1'b0);
    n_cmp++;
    if (r_stall_cnt != 5 || r_stall_bad != 0) begin
      n_bad++;
      $display("FAIL stall_hold: got %0d stall cycles %0d moves want 5 0", r_stall_cnt,
               r_stall_bad);
    end
    n_cmp++;
    if (r_en_cycles != Len || r_bc_final != Len) begin
      n_bad++;
      $display("FAIL stall_count: got en=%0d bc=%0d want %0d", r_en_cycles, r_bc_final, Len);
    end
    n_cmp++;
    if (chain0 !== basic_chain) begin
      n_bad++;
      $display("FAIL stall_chain: got %h want %h", chain0, basic_chain);
    end
  endtask

  task automatic test_readback;
    logic [Len-1:0] p;
    int pop, k;
    p = '0;
    pop = 0;
    while (pop < 27) begin
      k = int'($urandom_range(Len - 1, 0));
      if (!p[k]) begin
        p[k] = 1'b1;
        pop++;
      end
    end
    preload(p);
    fill_words(2);
    run_load(-1, 0, 1'b0);
    n_cmp++;
    if (r_ro_at_done != 27 || int'(ro0) != 27) begin
      n_bad++;
      $display("FAIL readback_27: got %0d held %0d want 27", r_ro_at_done, ro0);
    end
    n_cmp++;
    if (chain0 !== '1) begin
      n_bad++;
      $display("FAIL readback_ones_chain: got %h want all ones", chain0);
    end
    run_load(-1, 0, 1'b0);
    n_cmp++;
    if (r_ro_at_done != Len) begin
      n_bad++;
      $display("FAIL readback_full: got %0d want %0d", r_ro_at_done, Len);
    end
  endtask

  task automatic test_start_ignored;
    logic [Len-1:0] exp;
    fill_words(1);
    exp = stream_of();
    run_load(-1, 0, 1'b1);
    n_cmp++;
    if (r_done_cnt != 1 || r_bc_bad != 0) begin
      n_bad++;
      $display("FAIL start_busy: got done=%0d bc_bad=%0d want 1 0", r_done_cnt, r_bc_bad);
    end
    n_cmp++;
    if (r_idle_bad != 0 || r_bc_final != Len) begin
      n_bad++;
      $display("FAIL start_in_done: got idle_bad=%0d bc=%0d want 0 %0d", r_idle_bad,
               r_bc_final, Len);
    end
    n_cmp++;
    if (chain0 !== exp) begin
      n_bad++;
      $display("FAIL start_chain: got %h want %h", chain0, exp);
    end
  endtask

  task automatic test_random;
    logic [Len-1:0] exp, old;
    int s_idx, s_len;
    for (int it = 0; it < 4; it++) begin
      fill_words(1);
      exp   = stream_of();
      old   = chain0;
      s_idx = int'($urandom_range(NeedWords - 1, 0));
      s_len = int'($urandom_range(6, 1));
      run_load(s_idx, s_len, 1'b0);
      n_cmp++;
      if (chain0 !== exp || r_ro_at_done != popcount(old)) begin
        n_bad++;
        $display("FAIL random_%0d: got chain %h ro %0d want %h %0d", it, chain0,
                 r_ro_at_done, exp, popcount(old));
      end
      n_cmp++;
      if (r_en_cycles != Len || r_xfers != NeedWords || r_stall_cnt != s_len) begin
        n_bad++;
        $display("FAIL random_cnt_%0d: got en=%0d xf=%0d st=%0d want %0d %0d %0d", it,
                 r_en_cycles, r_xfers, r_stall_cnt, Len, NeedWords, s_len);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    logic [Len-1:0] exp, old;
    int cyc;
    bit hit;
    cyc = 0;
    hit = 1'b0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    valid0 = 1'b1;
    while (cyc < 100) begin
      if (int'(bc0) == 20) begin
        hit = 1'b1;
        break;
      end
      data0 = Ww'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (!hit || en0 !== 1'b1) begin
      n_bad++;
      $display("FAIL midload_reach: got hit=%0d en=%0d want 1 1", hit, en0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({en0, head0, ready0, busy0, done0} !== 5'b0 || bc0 !== '0 || ro0 !== '0) begin
      n_bad++;
      $display("FAIL midload_reset: got flags %b bc %0d ro %0d want 0", {en0, head0, ready0,
               busy0, done0}, bc0, ro0);
    end
    valid0 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    fill_words(1);
    exp = stream_of();
    old = chain0;
    run_load(-1, 0, 1'b0);
    n_cmp++;
    if (chain0 !== exp || r_bc_final != Len || r_ro_at_done != popcount(old)) begin
      n_bad++;
      $display("FAIL midload_reload: got chain %h bc %0d ro %0d want %h %0d %0d", chain0,
               r_bc_final, r_ro_at_done, exp, Len, popcount(old));
    end
  endtask

  task automatic test_single_bit;
    logic [Ww-1:0] w;
    int en_n, last_en, done_cyc, xf, rdy_shift;
    logic bc_done;
    w = Ww'($urandom);
    en_n = 0; last_en = -10; done_cyc = -1; xf = 0; rdy_shift = 0; bc_done = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    valid1 = 1'b1;
    data1  = w;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (en1) begin
        en_n++;
        last_en = cyc;
        if (ready1) rdy_shift++;
      end
      if (done1) begin
        done_cyc = cyc;
        bc_done  = bc1[0];
        break;
      end
      if (valid1 && ready1) xf++;
      @(posedge clk); #1;
    end
    valid1 = 1'b0;
    n_cmp++;
    if (en_n != 1 || done_cyc != last_en + 1) begin
      n_bad++;
      $display("FAIL len1_timing: got en=%0d done_at=%0d last_en=%0d want 1 last_en+1", en_n,
               done_cyc, last_en);
    end
    n_cmp++;
    if (rdy_shift != 0 || xf != 1) begin
      n_bad++;
      $display("FAIL len1_ready: got shift_ready=%0d xfers=%0d want 0 1", rdy_shift, xf);
    end
    n_cmp++;
    if (chain1 !== w[0] || bc_done !== 1'b1) begin
      n_bad++;
      $display("FAIL len1_data: got chain=%0d bc=%0d want %0d 1", chain1, bc_done, w[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_readback();
    test_start_ignored();
    test_random();
    test_reset_mid_load();
    test_single_bit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives one configuration chain (CCFF) from the programming side: accepts configuration words over a valid/ready stream and serialises them onto ccff_head, with config_enable gating each shift.
- Reads back the bits leaving the chain on ccff_tail during the same shifts.
- Sits between the bitstream source (JTAG/SPI programming front-end) and the ccff_head/ccff_tail/config_enable ports of a tile chain, such as a CLB's frac_lut6 sram+mode memory.

Parameters:
- CHAIN_LEN, 66, number of CCFF bits in the driven chain (64 LUT sram + 2 mode), must be >= 1.
- WORD_W, 8, width of input configuration words, must be >= 1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counters.

Ports:
- prog_clock  input  1  programming clock; chain and loader share it.
- prog_reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- word_valid  input  1  word_data is valid.
- word_data  input  WORD_W  configuration word; bit 0 is shifted first.
- word_ready  output  1  loader accepts word_data this cycle (transfer = valid & ready).
- config_enable  output  1  registered; chain shifts on a prog_clock edge while high.
- ccff_head  output  1  registered serial bit into the chain.
- ccff_tail  input  1  serial bit leaving the chain.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the CHAIN_LEN-th shift.
- bit_count  output  CNT_W  number of shifts completed in the current/last load.
- readback_ones  output  CNT_W  count of 1s sampled on ccff_tail during the load.

Behaviour:
- Reset (prog_reset low, asynchronous):
  - state=IDLE.
  - config_enable=0, ccff_head=0, word_ready=0, busy=0, done=0, bit_count=0, readback_ones=0.
  - Internal shift register and per-word counter cleared.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - word_ready=0.
  - start=1 → FETCH next cycle; bit_count and readback_ones clear to 0; busy=1.
- FETCH:
  - word_ready=1; config_enable=0, so the chain holds.
  - On transfer: load word into the shift register, set word_bits=WORD_W, go to SHIFT.
  - The first shift edge is the next cycle, so start-to-first-shift is 2 cycles with word_valid already high.
- SHIFT:
  - config_enable=1; ccff_head = current LSB of the shift register.
  - At each edge: shift register >>1, word_bits--, bit_count++.
  - At each edge: ccff_tail is sampled (the outgoing chain bit); readback_ones++ if 1.
- Gapless transfer:
  - word_ready is also 1 in SHIFT when word_bits==1 and bit_count < CHAIN_LEN-1.
  - A transfer in that cycle reloads the shift register, so ccff_head continues with no bubble and config_enable stays 1.
- Word exhausted, no transfer, bit_count < CHAIN_LEN after the edge → FETCH; config_enable drops to 0 (stall, chain holds).
- Final shift: when bit_count reaches CHAIN_LEN → DONE.
  - config_enable=0 in the following cycle.
  - Remaining bits of the last word are discarded (e.g. CHAIN_LEN=66, WORD_W=8: 9 words, only bits 0..1 of word 9 used).
  - No word is accepted beyond what CHAIN_LEN requires.
- DONE: done=1 for one cycle, busy=0, → IDLE. bit_count and readback_ones hold until the next start.
- Exactly CHAIN_LEN edges with config_enable=1 per load, regardless of stalls.
- start while busy is ignored (no restart, no counter clear).
- start in the DONE cycle is ignored; start must be reissued in IDLE.
- Reset mid-load:
  - Immediate return to reset values; config_enable=0 asynchronously.
  - The chain is left partially loaded; the next load fully rewrites it.
- ccff_head and config_enable are flops clocked by prog_clock; no combinational path from ccff_tail to any output.
- word_ready is a decode of registered state/counters only; it does not depend combinationally on word_valid.

Test Plan:
1. CHAIN_LEN=66, WORD_W=8; 9 words 0x01..0x09 presented back-to-back with word_valid high.
   → config_enable high for exactly 66 consecutive cycles.
   → Chain model holds bits LSB-first 0x01..0x08 then bits 0..1 of 0x09.
   → done pulses once; bit_count=66; word_ready never high after the 9th transfer.
2. Same load with word_valid dropped for 5 cycles before word 4.
   → config_enable low for those cycles; the chain model is unchanged during the stall.
   → Final chain content and bit_count=66 identical to scenario 1.
3. Readback: chain model preloaded with 0x2A5…(27 ones total), then all-0xFF words loaded.
   → readback_ones=27 at done; chain now all ones.
   → A second all-ones load gives readback_ones=66.
4. Reset asserted mid-load after 20 shifts.
   → All outputs at reset values in the same cycle; config_enable=0.
   → A new start fully reloads with bit_count=66.
5. start pulsed during SHIFT and in the DONE cycle → ignored; no counter clear; exactly one done per accepted start.
6. CHAIN_LEN=1, WORD_W=8: single transfer.
   → One shift edge; done 1 cycle after it; word_ready was never asserted in SHIFT.
